// File: rtl/switch_pkg.sv
// Shared types and helpers for the round-robin switch scheduler.
// The destination field is always the low bits of a word.
package switch_pkg;

    localparam int NUM_PORTS_MAX = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        GRANT
    } sched_state_t;

    function automatic int unsigned dest_of(
        input logic [31:0] word,
        input int          dest_w
    );
        logic [31:0] m;
        m = (32'd1 << dest_w) - 32'd1;
        return word & m;
    endfunction

endpackage

// File: rtl/switch_scheduler_rr_if.sv
// RAM-side bus of the scheduler: input RAM read ports,
// ingress write pointers and output RAM write ports.
interface switch_scheduler_rr_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12
);
    logic [NUM_PORTS-1:0][ADDR_W-1:0] in_wr_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] in_rd_data;
    logic [NUM_PORTS-1:0]             in_rden;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] in_rd_addr;
    logic [NUM_PORTS-1:0]             out_wr_en;
    logic [NUM_PORTS-1:0][DATA_W-1:0] out_wr_data;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] out_wr_addr;

    modport master (
        input  in_wr_addr,
        input  in_rd_data,
        output in_rden,
        output in_rd_addr,
        output out_wr_en,
        output out_wr_data,
        output out_wr_addr
    );

    modport slave (
        output in_wr_addr,
        output in_rd_data,
        input  in_rden,
        input  in_rd_addr,
        input  out_wr_en,
        input  out_wr_data,
        input  out_wr_addr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr,
// wrapping to the lowest request when none lies above it.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         hit_hi;
    logic         hit_lo;

    always_comb begin
        hi     = '0;
        lo     = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !hit_lo) begin
                lo[i]  = 1'b1;
                hit_lo = 1'b1;
            end
            if (req[i] && (i >= int'(ptr)) && !hit_hi) begin
                hi[i]  = 1'b1;
                hit_hi = 1'b1;
            end
        end
        grant    = hit_hi ? hi : lo;
        next_ptr = ptr;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/switch_scheduler_rr.sv
// Drains N input RAMs into N output RAMs in 2-cycle READ/GRANT
// rounds, arbitrating each output round-robin among its requesters.
module switch_scheduler_rr
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    switch_scheduler_rr_if.master bus,
    output logic                  drop,
    output logic                  idle
);
    localparam int DEST_W = $clog2(NUM_PORTS);

    sched_state_t state;

    logic [NUM_PORTS-1:0]                mask;
    logic [NUM_PORTS-1:0]                nonempty;
    logic [NUM_PORTS-1:0]                bad;
    logic [NUM_PORTS-1:0]                adv;
    logic [NUM_PORTS-1:0]                wr_en;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]    rd_addr;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]    wr_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    wr_data;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    win_data;
    logic [NUM_PORTS-1:0][DEST_W-1:0]    rr_ptr;
    logic [NUM_PORTS-1:0][DEST_W-1:0]    next_ptr;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] grant;

    always_comb begin
        nonempty = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            nonempty[i] = rd_addr[i] != bus.in_wr_addr[i];
        end
    end

    assign bus.in_rden     = (state == READ) ? nonempty : '0;
    assign bus.in_rd_addr  = rd_addr;
    assign bus.out_wr_en   = wr_en;
    assign bus.out_wr_data = wr_data;
    assign bus.out_wr_addr = wr_addr;

    assign idle = (state != GRANT) && (nonempty == '0) && (wr_en == '0);

    // req[j][i]: input i wants output j this round
    always_comb begin
        int unsigned d;
        d   = 0;
        req = '0;
        bad = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (state == GRANT && mask[i]) begin
                d = dest_of(32'(bus.in_rd_data[i]), DEST_W);
                if (d >= unsigned'(NUM_PORTS)) begin
                    bad[i] = 1'b1;
                end
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (d == unsigned'(j)) begin
                        req[j][i] = 1'b1;
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
        rr_arbiter #(
            .N (NUM_PORTS)
        ) u_arb (
            .req      (req[j]),
            .ptr      (rr_ptr[j]),
            .grant    (grant[j]),
            .next_ptr (next_ptr[j])
        );
    end

    always_comb begin
        adv      = bad;
        win_data = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[j][i]) begin
                    adv[i]      = 1'b1;
                    win_data[j] = bus.in_rd_data[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask    <= '0;
            rd_addr <= '0;
            rr_ptr  <= '0;
            wr_en   <= '0;
            wr_data <= '0;
            wr_addr <= '0;
            drop    <= 1'b0;
        end else begin
            wr_en <= '0;
            drop  <= 1'b0;
            // write address moves on only after it was presented
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (wr_en[j]) begin
                    wr_addr[j] <= wr_addr[j] + 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state <= READ;
                    end
                end
                READ: begin
                    mask  <= nonempty;
                    state <= GRANT;
                end
                GRANT: begin
                    state  <= enable ? READ : IDLE;
                    drop   <= |bad;
                    rr_ptr <= next_ptr;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        rd_addr[i] <= rd_addr[i] + ADDR_W'(adv[i]);
                    end
                    for (int j = 0; j < NUM_PORTS; j++) begin
                        if (|grant[j]) begin
                            wr_en[j]   <= 1'b1;
                            wr_data[j] <= win_data[j];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_switch_scheduler_rr.sv
// Bench for switch_scheduler_rr: directed scenarios plus random
// traffic checked against a queue-based round-robin model.
module tb_switch_scheduler_rr;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 12;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic enable3 = 1'b0;
    logic drop, idle, drop3, idle3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    switch_scheduler_rr_if #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
    switch_scheduler_rr_if #(.NUM_PORTS(3), .DATA_W(DW), .ADDR_W(AW)) bus3 ();

    switch_scheduler_rr #(.NUM_PORTS(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus),
        .drop   (drop),
        .idle   (idle)
    );

    switch_scheduler_rr #(.NUM_PORTS(3), .DATA_W(DW), .ADDR_W(AW)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable3),
        .bus    (bus3),
        .drop   (drop3),
        .idle   (idle3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // input RAMs with one cycle of registered read latency
    logic [DW-1:0] mem  [N][4096];
    logic [DW-1:0] mem3 [3][16];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (bus.in_rden[i])
                bus.in_rd_data[i] <= mem[i][bus.in_rd_addr[i]];
        for (int i = 0; i < 3; i++)
            if (bus3.in_rden[i])
                bus3.in_rd_data[i] <= mem3[i][bus3.in_rd_addr[i][3:0]];
    end

    rec_t got [N][$];
    rec_t exp [N][$];
    int drop3_n = 0;
    int wen3_n [3] = '{0, 0, 0};

    always @(negedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < N; j++)
                if (bus.out_wr_en[j])
                    got[j].push_back('{a: bus.out_wr_addr[j],
                                       d: bus.out_wr_data[j], c: cyc});
            if (drop3) drop3_n++;
            for (int j = 0; j < 3; j++)
                if (bus3.out_wr_en[j]) wen3_n[j]++;
        end
    end

    // reference model: per-input FIFOs, per-output RR pointer
    logic [DW-1:0] mq [N][$];
    int            rr [N];
    logic [AW-1:0] oaddr [N];

    int exp_src  [6] = '{0, 1, 3, 0, 1, 3};
    int wrap_exp [3] = '{4094, 4095, 0};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk(input int src, input int tag,
                                       input int dest);
        return (32'(src) << 28) | ((32'(tag) & 32'hFFF) << 16)
             | (32'(dest) & 32'h3);
    endfunction

    task automatic push(input int i, input logic [31:0] w);
        mem[i][bus.in_wr_addr[i]] = w;
        bus.in_wr_addr[i] = bus.in_wr_addr[i] + 12'd1;
        mq[i].push_back(w);
    endtask

    task automatic model_run();
        int  win [N];
        int  idx;
        bit  pending;
        pending = 1'b0;
        for (int i = 0; i < N; i++)
            if (mq[i].size() > 0) pending = 1'b1;
        while (pending) begin
            for (int j = 0; j < N; j++) begin
                win[j] = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (rr[j] + k) % N;
                    if (win[j] < 0 && mq[idx].size() > 0)
                        if (int'(mq[idx][0][1:0]) == j) win[j] = idx;
                end
            end
            for (int j = 0; j < N; j++) begin
                if (win[j] >= 0) begin
                    exp[j].push_back('{a: oaddr[j], d: mq[win[j]][0], c: 0});
                    oaddr[j] = oaddr[j] + 12'd1;
                    rr[j] = (win[j] + 1) % N;
                end
            end
            for (int j = 0; j < N; j++)
                if (win[j] >= 0) void'(mq[win[j]].pop_front());
            pending = 1'b0;
            for (int i = 0; i < N; i++)
                if (mq[i].size() > 0) pending = 1'b1;
        end
    endtask

    task automatic drain(input int budget);
        model_run();
        enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k < budget && idle !== 1'b1; k++) @(negedge clk);
        chk("drain_idle", 64'(idle), 64'd1);
        enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        int bad;
        for (int j = 0; j < N; j++) begin
            bad = 0;
            chk($sformatf("%s_len%0d", tag, j),
                64'(got[j].size()), 64'(exp[j].size()));
            for (int k = 0; k < exp[j].size() && k < got[j].size(); k++)
                if (got[j][k].a !== exp[j][k].a || got[j][k].d !== exp[j][k].d)
                    bad++;
            chk($sformatf("%s_data%0d", tag, j), 64'(bad), 64'd0);
            got[j].delete();
            exp[j].delete();
        end
        chk({tag, "_empty"}, 64'(bus.in_rd_addr), 64'(bus.in_wr_addr));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rden"}, 64'(bus.in_rden), 64'd0);
        chk({tag, "_rdaddr"}, 64'(bus.in_rd_addr), 64'd0);
        chk({tag, "_wren"}, 64'(bus.out_wr_en), 64'd0);
        chk({tag, "_wrdata"}, 64'(|bus.out_wr_data), 64'd0);
        chk({tag, "_wraddr"}, 64'(bus.out_wr_addr), 64'd0);
        chk({tag, "_drop"}, 64'(drop), 64'd0);
        chk({tag, "_idle"}, 64'(idle), 64'd1);
    endtask

    initial begin
        int c;
        int n;
        logic [31:0] w;

        bus.in_wr_addr  = '0;
        bus3.in_wr_addr = '0;
        for (int j = 0; j < N; j++) begin
            rr[j] = 0;
            oaddr[j] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // NUM_PORTS=3: dest 3 is dropped, dest 2 still delivered
        mem3[0][0] = 32'h0000_ABC3;
        mem3[1][0] = 32'h0000_5552;
        bus3.in_wr_addr[0] = 12'd1;
        bus3.in_wr_addr[1] = 12'd1;
        enable3 = 1'b1;
        repeat (10) @(negedge clk);
        enable3 = 1'b0;
        repeat (4) @(negedge clk);
        chk("inv_drop_cnt", 64'(drop3_n), 64'd1);
        chk("inv_wen01", 64'(wen3_n[0] + wen3_n[1]), 64'd0);
        chk("inv_wen2", 64'(wen3_n[2]), 64'd1);
        chk("inv_data2", 64'(bus3.out_wr_data[2]), 64'h5552);
        chk("inv_rdaddr0", 64'(bus3.in_rd_addr[0]), 64'd1);
        chk("inv_rdaddr1", 64'(bus3.in_rd_addr[1]), 64'd1);
        chk("inv_idle", 64'(idle3), 64'd1);

        // single path: input 0, three words to output 2
        for (int k = 0; k < 3; k++) push(0, mk(0, k, 2));
        c = cyc;
        drain(100);
        chk("sp_count", 64'(got[2].size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got[2].size()) begin
                chk($sformatf("sp_addr%0d", k), 64'(got[2][k].a), 64'(k));
                chk($sformatf("sp_cyc%0d", k), 64'(got[2][k].c),
                    64'(c + 3 + 2 * k));
            end
        end
        chk("sp_rdaddr0", 64'(bus.in_rd_addr[0]), 64'd3);
        chk("sp_idle", 64'(idle), 64'd1);
        compare("sp");

        // contention: inputs 0,1,3 each send two words to output 1
        for (int k = 0; k < 2; k++) begin
            push(0, mk(0, k, 1));
            push(1, mk(1, k, 1));
            push(3, mk(3, k, 1));
        end
        drain(200);
        chk("ct_count", 64'(got[1].size()), 64'd6);
        for (int k = 0; k < 6; k++)
            if (k < got[1].size())
                chk($sformatf("ct_src%0d", k),
                    64'(got[1][k].d[31:28]), 64'(exp_src[k]));
        compare("ct");

        // parallel: four distinct destinations in one round
        for (int i = 0; i < N; i++) push(i, mk(i, 9, 3 - i));
        c = cyc;
        drain(100);
        for (int j = 0; j < N; j++) begin
            chk($sformatf("par_n%0d", j), 64'(got[j].size()), 64'd1);
            if (got[j].size() > 0)
                chk($sformatf("par_cyc%0d", j), 64'(got[j][0].c), 64'(c + 3));
        end
        compare("par");

        // random traffic
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                n = int'($urandom_range(0, 5));
                for (int k = 0; k < n; k++) begin
                    w = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
                    push(i, w);
                end
            end
            drain(500);
            compare($sformatf("rnd%0d", t));
        end

        // wrap: bring input 0 up to 4094, then cross the top
        n = 4094 - int'(bus.in_wr_addr[0]);
        for (int k = 0; k < n; k++)
            push(0, ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)));
        drain(20000);
        compare("fill");
        chk("wrap_pre", 64'(bus.in_rd_addr[0]), 64'd4094);
        for (int k = 0; k < 3; k++) push(0, mk(0, int'(bus.in_wr_addr[0]), 0));
        drain(200);
        chk("wrap_count", 64'(got[0].size() + got[1].size() + got[2].size()
                              + got[3].size()), 64'd3);
        for (int k = 0; k < 3; k++)
            if (k < got[0].size())
                chk($sformatf("wrap_addr%0d", k),
                    64'(got[0][k].d[27:16]), 64'(wrap_exp[k]));
        chk("wrap_rdaddr", 64'(bus.in_rd_addr[0]), 64'd1);
        compare("wrap");

        // reset during GRANT abandons the round
        push(0, mk(0, 1, 1));
        push(0, mk(0, 2, 1));
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        bus.in_wr_addr = '0;
        bus3.in_wr_addr = '0;
        #1;
        check_reset_state("midrst");
        for (int j = 0; j < N; j++) begin
            mq[j].delete();
            got[j].delete();
            rr[j] = 0;
            oaddr[j] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_nowrite", 64'(got[0].size() + got[1].size()
                                  + got[2].size() + got[3].size()), 64'd0);
        chk("midrst_rdaddr", 64'(bus.in_rd_addr), 64'd0);

        // traffic resumes from address 0 after reset
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++)
                push(i, ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3)));
        drain(500);
        compare("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
